// File: rtl/flash_read_arbiter.sv
// Two-port read sequencer for the 8-bit parallel NOR flash.
// Owns flash reset sequencing; assembles 1/2/4 byte reads little-endian.
module flash_read_arbiter #(
  parameter int ADDR_W     = 27,
  parameter int RD_WAIT    = 3,
  parameter int RST_CYCLES = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [31:0]       i_rdata,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [1:0]        d_size,
  output logic              d_ack,
  output logic [31:0]       d_rdata,
  output logic              busy,
  input  logic              RDY_BSY,
  output logic              nMEMRST,
  output logic              nBYTE,
  output logic              nCE,
  output logic              nWE,
  output logic              nOE,
  output logic [ADDR_W-1:0] ADDR,
  input  logic [7:0]        DATA_IN
);

  localparam int CMAX = (RST_CYCLES > RD_WAIT) ? RST_CYCLES : RD_WAIT;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [2:0] {
    RST_PULSE,
    RST_WAIT,
    IDLE,
    SETUP,
    STROBE
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          ptr;
  logic          gnt;
  logic [1:0]    k;
  logic [1:0]    last;
  logic          both;
  logic          grant;
  logic          pick;
  logic [1:0]    d_last;

  assign nBYTE = 1'b0;
  assign nWE   = 1'b1;

  // ptr remembers the last contended winner; 0 = fetch, 1 = load
  always_comb begin
    both  = i_req & d_req;
    grant = RDY_BSY & (i_req | d_req);
    pick  = 1'b0;
    unique case (1'b1)
      both:            pick = ~ptr;
      d_req & ~i_req:  pick = 1'b1;
      default:         pick = 1'b0;
    endcase
    d_last = 2'd3;
    unique case (d_size)
      2'd0:    d_last = 2'd0;
      2'd1:    d_last = 2'd1;
      default: d_last = 2'd3;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= RST_PULSE;
      cnt     <= '0;
      ptr     <= 1'b0;
      gnt     <= 1'b0;
      k       <= 2'd0;
      last    <= 2'd0;
      nMEMRST <= 1'b0;
      nCE     <= 1'b1;
      nOE     <= 1'b1;
      ADDR    <= '0;
      i_ack   <= 1'b0;
      d_ack   <= 1'b0;
      i_rdata <= '0;
      d_rdata <= '0;
      busy    <= 1'b1;
    end else begin
      i_ack <= 1'b0;
      d_ack <= 1'b0;
      unique case (state)
        RST_PULSE: begin
          if (cnt == CW'(RST_CYCLES - 1)) begin
            cnt     <= '0;
            nMEMRST <= 1'b1;
            state   <= RST_WAIT;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RST_WAIT: begin
          if (RDY_BSY) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        IDLE: begin
          if (grant) begin
            gnt <= pick;
            if (both) ptr <= pick;
            ADDR <= pick ? d_addr : i_addr;
            last <= pick ? d_last : 2'd3;
            k    <= 2'd0;
            if (pick) d_rdata <= '0;
            else      i_rdata <= '0;
            nCE   <= 1'b0;
            busy  <= 1'b1;
            state <= SETUP;
          end
        end
        SETUP: begin
          nOE   <= 1'b0;
          cnt   <= '0;
          state <= STROBE;
        end
        STROBE: begin
          if (cnt == CW'(RD_WAIT - 1)) begin
            nOE <= 1'b1;
            cnt <= '0;
            if (gnt) d_rdata[{k, 3'b000} +: 8] <= DATA_IN;
            else     i_rdata[{k, 3'b000} +: 8] <= DATA_IN;
            if (k != last) begin
              k     <= k + 2'd1;
              ADDR  <= ADDR + ADDR_W'(1);
              state <= SETUP;
            end else begin
              nCE <= 1'b1;
              if (gnt) d_ack <= 1'b1;
              else     i_ack <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= RST_PULSE;
      endcase
    end
  end

endmodule
